// File: rtl/spi_slave_core.sv
// SPI slave (CPOL=0, sample on sclk rise, shift on sclk fall) with a one-word TX buffer, oversampled on clk.
// Optional tx_underrun flag when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave_core #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DWIDTH-1:0] tx_din,
  input  logic              tx_wr,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_dout,
  output logic              rx_valid,
`ifdef SPI_SLAVE_UNDERRUN_EN
  output logic              tx_underrun,
`endif
  output logic              busy
);

  localparam int CW = (DWIDTH > 2) ? $clog2(DWIDTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, next_state;

  logic              sclk_s1, sclk_s2, sclk_d;
  logic              ss_s1, ss_s2, ss_d;
  logic              mosi_s1, mosi_s2;
  logic              sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [DWIDTH-1:0] shift_reg;
  logic [DWIDTH-2:0] rx_shift;
  logic [DWIDTH-1:0] rx_next;
  logic [DWIDTH-1:0] tx_buf;
  logic              tx_full;
  logic [CW-1:0]     bit_cnt;
  logic              word_done;
  logic              load, shift_out, sample_in, tx_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
      ss_s1   <= 1'b1; ss_s2   <= 1'b1; ss_d   <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
      ss_s1   <= ss_n;    ss_s2   <= ss_s1;   ss_d   <= ss_s2;
      mosi_s1 <= mosi;    mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign ss_fall   = ~ss_s2 & ss_d;
  assign ss_rise   = ss_s2 & ~ss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift_out  = 1'b0;
    sample_in  = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          next_state = ACTIVE;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          next_state = IDLE;
        end else begin
          // The falling edge after a completed word starts the next word rather than shifting.
          load      = sclk_fall & word_done;
          shift_out = sclk_fall & ~word_done;
          sample_in = sclk_rise;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign tx_accept = tx_wr & ~tx_full;
  assign rx_next   = {rx_shift, mosi_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (load && tx_full) begin
      tx_full <= 1'b0;
    end else if (tx_accept) begin
      tx_buf  <= tx_din;
      tx_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= tx_full ? tx_buf : '0;
    end else if (shift_out) begin
      shift_reg <= {shift_reg[DWIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift  <= '0;
      rx_dout   <= '0;
      rx_valid  <= 1'b0;
      bit_cnt   <= '0;
      word_done <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == ACTIVE && ss_rise) begin
        bit_cnt   <= '0;
        word_done <= 1'b0;
      end else if (load) begin
        word_done <= 1'b0;
      end else if (sample_in) begin
        rx_shift <= rx_next[DWIDTH-2:0];
        if (bit_cnt == CW'(DWIDTH-1)) begin
          bit_cnt   <= '0;
          rx_dout   <= rx_next;
          rx_valid  <= 1'b1;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_EN
  // A load from an empty buffer wins over a simultaneous write, which is kept for the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tx_underrun <= 1'b0;
    else if (load && !tx_full) tx_underrun <= 1'b1;
    else if (tx_accept)        tx_underrun <= 1'b0;
  end
`endif

  assign miso     = (state == ACTIVE) & shift_reg[DWIDTH-1];
  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = ~tx_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core (DWIDTH=8): drives an SPI master model and checks words and flags.
module tb_spi_slave_core;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe;
  logic [7:0] tx_din = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_dout;
  logic       rx_valid;
  logic       busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
`endif

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  logic [7:0] rv_log [0:63];

  spi_slave_core #(.DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_din(tx_din), .tx_wr(tx_wr),
    .tx_ready(tx_ready), .rx_dout(rx_dout), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_UNDERRUN_EN
    .tx_underrun(tx_underrun),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Counts cycles with rx_valid high, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid) begin
      rv_log[rv_cnt[5:0]] <= rx_dout;
      rv_cnt <= rv_cnt + 1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_din = d;
    tx_wr  = 1'b1;
    @(negedge clk);
    tx_wr  = 1'b0;
  endtask

  task automatic select;
    @(negedge clk);
    ss_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic deselect;
    @(negedge clk);
    ss_n = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mosi = tx[7-i];
      wait_clks(HALF);
      rx   = {rx[6:0], miso};
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({miso, miso_oe, tx_ready, rx_dout, rx_valid, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: miso=%b oe=%b tx_ready=%b rx_dout=%h rx_valid=%b busy=%b, want 0 0 1 00 0 0",
               tag, miso, miso_oe, tx_ready, rx_dout, rx_valid, busy);
    end
`ifdef SPI_SLAVE_UNDERRUN_EN
    checks++;
    if (tx_underrun !== 1'b0) begin
      errors++;
      $display("FAIL %s_underrun: got %b want 0", tag, tx_underrun);
    end
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_basic;
    logic [7:0] got;
    int base;
    base = rv_cnt;
    write_tx(8'hA5);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_full: tx_ready=%b want 0", tx_ready); end
    select;
    checks++;
    if ({busy, miso_oe, tx_ready} !== 3'b111) begin
      errors++; $display("FAIL basic_selected: busy/oe/ready=%b%b%b want 111", busy, miso_oe, tx_ready);
    end
    spi_bits(8'h3C, 8, got);
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h want a5", got); end
    deselect;
    checks++;
    if (rx_dout !== 8'h3C) begin errors++; $display("FAIL basic_rx_dout: got %h want 3c", rx_dout); end
    checks++;
    if (rv_cnt - base !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", rv_cnt - base); end
    checks++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      errors++; $display("FAIL basic_idle: busy/oe/miso=%b%b%b want 000", busy, miso_oe, miso);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] g0, g1;
    int base;
    base = rv_cnt;
    write_tx(8'h11);
    select;
    write_tx(8'h22);
    spi_bits(8'h81, 8, g0);
    spi_bits(8'h7E, 8, g1);
    deselect;
    checks++;
    if ({g0, g1} !== 16'h1122) begin errors++; $display("FAIL b2b_miso: got %h %h want 11 22", g0, g1); end
    checks++;
    if (rv_cnt - base !== 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d want 2", rv_cnt - base);
    end else begin
      checks++;
      if ({rv_log[base[5:0]], rv_log[6'(base + 1)]} !== 16'h817E) begin
        errors++; $display("FAIL b2b_words: got %h %h want 81 7e", rv_log[base[5:0]], rv_log[6'(base + 1)]);
      end
    end
  endtask

  task automatic test_abort;
    logic [7:0] got;
    int base;
    base = rv_cnt;
    select;
    spi_bits(8'hFF, 5, got);
    deselect;
    checks++;
    if (rv_cnt - base !== 0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", rv_cnt - base); end
    checks++;
    if (rx_dout !== 8'h7E) begin errors++; $display("FAIL abort_rx_dout: got %h want 7e", rx_dout); end
    select;
    spi_bits(8'h5A, 8, got);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL empty_miso: got %h want 00", got); end
`ifdef SPI_SLAVE_UNDERRUN_EN
    checks++;
    if (tx_underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", tx_underrun); end
`endif
    deselect;
    checks++;
    if (rx_dout !== 8'h5A || rv_cnt - base !== 1) begin
      errors++; $display("FAIL after_abort: rx_dout=%h pulses=%0d want 5a 1", rx_dout, rv_cnt - base);
    end
  endtask

  task automatic test_ignored_write;
    logic [7:0] got;
    write_tx(8'h33);
    write_tx(8'h44);
`ifdef SPI_SLAVE_UNDERRUN_EN
    checks++;
    if (tx_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear: got %b want 0", tx_underrun); end
`endif
    select;
    spi_bits(8'h00, 8, got);
    deselect;
    checks++;
    if (got !== 8'h33) begin errors++; $display("FAIL ignored_write: got %h want 33", got); end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL ignored_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_idle_sclk;
    logic [7:0] got;
    int base;
    base = rv_cnt;
    for (int i = 0; i < 3; i++) begin
      wait_clks(HALF); sclk = 1'b1;
      wait_clks(HALF); sclk = 1'b0;
    end
    wait_clks(HALF);
    checks++;
    if ({busy, miso_oe, miso} !== 3'b000 || rv_cnt != base) begin
      errors++; $display("FAIL idle_sclk: busy/oe/miso=%b%b%b pulses=%0d want 000 0", busy, miso_oe, miso, rv_cnt - base);
    end
    write_tx(8'h69);
    select;
    spi_bits(8'hC3, 8, got);
    deselect;
    checks++;
    if ({got, rx_dout} !== 16'h69C3 || rv_cnt - base !== 1) begin
      errors++; $display("FAIL idle_then_xfer: miso=%h rx=%h pulses=%0d want 69 c3 1", got, rx_dout, rv_cnt - base);
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] got;
    int base;
    base = rv_cnt;
    write_tx(8'hF0);
    select;
    spi_bits(8'hE7, 3, got);
    @(negedge clk);
    rst  = 1'b1;
    ss_n = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    wait_clks(3);
    rst = 1'b0;
    wait_clks(HALF);
    check_reset_outputs("rst_mid_released");
    write_tx(8'h5C);
    select;
    spi_bits(8'h96, 8, got);
    deselect;
    checks++;
    if ({got, rx_dout} !== 16'h5C96 || rv_cnt - base !== 1) begin
      errors++; $display("FAIL rst_mid_xfer: miso=%h rx=%h pulses=%0d want 5c 96 1", got, rx_dout, rv_cnt - base);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_abort;
    test_ignored_write;
    test_idle_sclk;
    test_rst_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 Parameter: DWIDTH, default 8, SHALL set the transfer word width in bits (minimum 2).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous and active-high.
REQ-004 sclk  input  1  SHALL be the SPI serial clock from the master (CPOL=0); asynchronous to clk.
REQ-005 ss_n  input  1  SHALL be the active-low slave select from the master; asynchronous.
REQ-006 mosi  input  1  SHALL be the master-out serial data; asynchronous.
REQ-007 miso  output  1  SHALL be the slave-out serial data, MSB first.
REQ-008 miso_oe  output  1  SHALL be high only while the slave is selected (tristate enable for the pad).
REQ-009 tx_din  input  DWIDTH  SHALL be the word to transmit, written via tx_wr.
REQ-010 tx_wr  input  1  SHALL write tx_din into the one-word TX buffer when tx_ready=1.
REQ-011 tx_ready  output  1  SHALL be high when the TX buffer is empty.
REQ-012 rx_dout  output  DWIDTH  SHALL hold the last complete received word.
REQ-013 rx_valid  output  1  SHALL pulse high for exactly one clk cycle when rx_dout is updated.
REQ-014 busy  output  1  SHALL be high while the FSM is in state ACTIVE.

Function
REQ-015 sclk, ss_n, mosi SHALL each pass through a 2-flop synchronizer; edges SHALL be detected by comparing the synchronized value with a registered copy.
REQ-016 Mode matches the team's master: slave SHALL sample mosi on sclk rising edges and SHALL shift the next bit onto miso on sclk falling edges.
REQ-017 Supported timing: sclk high and low phases each >= 4 clk periods; ss_n setup to first sclk edge >= 4 clk periods.
REQ-018 FSM states: IDLE (ss_n high), ACTIVE (selected); IDLE->ACTIVE on synchronized ss_n falling edge; ACTIVE->IDLE on synchronized ss_n rising edge.
REQ-019 On IDLE->ACTIVE, the shift register SHALL load the TX buffer (tx_ready->1 the next cycle), or all-zeros if the buffer is empty; miso SHALL present its MSB.
REQ-020 A bit counter SHALL count detected sclk rising edges 0..DWIDTH-1 and wrap to 0 after the DWIDTH-th.
REQ-021 On the DWIDTH-th rising edge, rx_dout SHALL update to the DWIDTH sampled bits (first bit = MSB) and rx_valid SHALL assert in the clk cycle after edge detection.
REQ-022 At the first sclk falling edge after a word completes with ss_n still low, the shift register SHALL reload from the TX buffer (or all-zeros if empty), enabling back-to-back words.
REQ-023 tx_wr while tx_ready=0 SHALL be ignored; buffer contents unchanged.
REQ-024 tx_wr in the same cycle as a load from an empty buffer: the load SHALL use the fill word; the write SHALL be stored for the next word.
REQ-025 ss_n deassertion mid-word SHALL abort: no rx_valid, bit counter to 0, rx_dout unchanged, TX buffer unchanged.
REQ-026 miso SHALL be 0 and miso_oe 0 while in IDLE.
REQ-027 sclk edges while IDLE SHALL be ignored.

Reset
REQ-028 rst SHALL asynchronously force: state IDLE, synchronizers to idle levels (sclk 0, ss_n 1, mosi 0), bit counter 0, TX buffer empty.
REQ-029 Output reset values: miso=0, miso_oe=0, tx_ready=1, rx_dout=0, rx_valid=0, busy=0 (plus tx_underrun=0 when enabled).
REQ-030 rst asserted mid-transfer SHALL discard the partial word; after release, the slave SHALL wait for a fresh ss_n falling edge.

Configuration
REQ-031 Macro SPI_SLAVE_UNDERRUN_EN defined: output tx_underrun (1 bit) SHALL exist, SHALL set when a load (REQ-019/REQ-022) occurs with the buffer empty, and SHALL clear on the next accepted tx_wr or on rst.
REQ-032 Macro undefined: port tx_underrun SHALL be absent; fill-word behaviour unchanged.

Verification
REQ-033 tx_wr 0xA5 then master transfers 0x3C (DWIDTH=8) -> master receives 0xA5; rx_dout=0x3C with a single rx_valid pulse; tx_ready=1 after load.
REQ-034 Buffer 0x11 loaded; 2-word burst with ss_n held low, 0x22 written after the first load; master sends 0x81, 0x7E -> master receives 0x11, 0x22; two rx_valid pulses: 0x81, then 0x7E.
REQ-035 ss_n raised after 5 sclk rising edges -> no rx_valid; a following full 0x5A transfer yields rx_dout=0x5A.
REQ-036 Transfer with TX buffer empty -> master receives 0x00; with SPI_SLAVE_UNDERRUN_EN, tx_underrun=1 until the next tx_wr.
REQ-037 rst pulsed mid-word after 3 bits -> all outputs at reset values; no rx_valid; the next full transfer is received correctly.
